// File: rtl/score_tracker.sv
// Multi-player saturating round-score tracker with first-to-MAX_SCORE game-over detection.
// Optional round counter is built only when SCORE_TRACKER_ROUNDS_EN is defined.
module score_tracker #(
  parameter int PLAYERS   = 2,
  parameter int WIDTH     = 3,
  parameter int MAX_SCORE = 7,
  parameter int RWIDTH    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [PLAYERS-1:0]         win,
  input  logic [PLAYERS-1:0]         lose,
  output logic [PLAYERS*WIDTH-1:0]   score,
  output logic                       game_over,
  output logic [PLAYERS-1:0]         winner,
  output logic [RWIDTH-1:0]          rounds
);

  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_SCORE);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(32'd1);

  if ((MAX_SCORE < 1) || (MAX_SCORE > (2**WIDTH) - 1)) begin : g_bad_max
    $error("score_tracker: MAX_SCORE out of range for WIDTH");
  end
  if ((PLAYERS < 2) || (PLAYERS > 8)) begin : g_bad_players
    $error("score_tracker: PLAYERS must be 2..8");
  end

  state_t                     state_r, state_s;
  logic [PLAYERS*WIDTH-1:0]   score_r, score_s;
  logic [PLAYERS*WIDTH-1:0]   upd_s;
  logic [PLAYERS-1:0]         winner_r, winner_s;
  logic                       game_over_r, game_over_s;
  logic                       found_s;

  // Per-player saturating candidate score, independent of game state.
  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [WIDTH-1:0] cur_s;
    logic [WIDTH-1:0] nxt_s;

    always_comb begin
      cur_s = score_r[p*WIDTH +: WIDTH];
      nxt_s = cur_s;
      if (win[p] && !lose[p]) begin
        if (cur_s < MAX_V) begin
          nxt_s = cur_s + ONE_V;
        end else begin
          nxt_s = cur_s;
        end
      end else if (lose[p] && !win[p]) begin
        if (cur_s != ZERO_V) begin
          nxt_s = cur_s - ONE_V;
        end else begin
          nxt_s = cur_s;
        end
      end else begin
        nxt_s = cur_s;
      end
    end

    assign upd_s[p*WIDTH +: WIDTH] = nxt_s;
  end

  // Next-state logic: clear beats play updates; OVER freezes everything.
  always_comb begin
    state_s     = state_r;
    score_s     = score_r;
    winner_s    = winner_r;
    game_over_s = game_over_r;
    found_s     = 1'b0;
    if (clear) begin
      state_s     = ST_PLAY;
      score_s     = {(PLAYERS*WIDTH){1'b0}};
      winner_s    = {PLAYERS{1'b0}};
      game_over_s = 1'b0;
    end else begin
      case (state_r)
        ST_PLAY: begin
          score_s  = upd_s;
          winner_s = {PLAYERS{1'b0}};
          // Ascending scan so the lowest index wins a tie.
          for (int i = 0; i < PLAYERS; i++) begin
            if (!found_s && (upd_s[i*WIDTH +: WIDTH] == MAX_V)) begin
              found_s     = 1'b1;
              winner_s[i] = 1'b1;
            end else begin
              found_s = found_s;
            end
          end
          if (found_s) begin
            state_s     = ST_OVER;
            game_over_s = 1'b1;
          end else begin
            state_s     = ST_PLAY;
            game_over_s = 1'b0;
          end
        end
        ST_OVER: begin
          state_s     = ST_OVER;
          game_over_s = 1'b1;
        end
        default: begin
          state_s     = ST_PLAY;
          score_s     = {(PLAYERS*WIDTH){1'b0}};
          winner_s    = {PLAYERS{1'b0}};
          game_over_s = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_PLAY;
      score_r     <= {(PLAYERS*WIDTH){1'b0}};
      winner_r    <= {PLAYERS{1'b0}};
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      score_r     <= score_s;
      winner_r    <= winner_s;
      game_over_r <= game_over_s;
    end
  end

  assign score     = score_r;
  assign winner    = winner_r;
  assign game_over = game_over_r;

`ifdef SCORE_TRACKER_ROUNDS_EN
  localparam logic [RWIDTH-1:0] RMAX_V  = {RWIDTH{1'b1}};
  localparam logic [RWIDTH-1:0] RONE_V  = RWIDTH'(32'd1);

  logic [RWIDTH-1:0] rounds_r, rounds_s;

  // Saturating count of PLAY cycles with any round activity.
  always_comb begin
    rounds_s = rounds_r;
    if (clear) begin
      rounds_s = {RWIDTH{1'b0}};
    end else if ((state_r == ST_PLAY) && (|(win | lose)) && (rounds_r != RMAX_V)) begin
      rounds_s = rounds_r + RONE_V;
    end else begin
      rounds_s = rounds_r;
    end
  end

  // Round counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rounds_r <= {RWIDTH{1'b0}};
    end else begin
      rounds_r <= rounds_s;
    end
  end

  assign rounds = rounds_r;
`else
  assign rounds = {RWIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed self-checking bench for score_tracker (PLAYERS=2, WIDTH=3, MAX_SCORE=7, RWIDTH=6).
module tb_score_tracker;

`ifdef SCORE_TRACKER_ROUNDS_EN
  localparam bit ROUNDS_EN = 1'b1;
`else
  localparam bit ROUNDS_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       clear;
  logic [1:0] win;
  logic [1:0] lose;
  logic [5:0] score;
  logic       game_over;
  logic [1:0] winner;
  logic [5:0] rounds;

  int checks;
  int failures;

  score_tracker #(
    .PLAYERS(2), .WIDTH(3), .MAX_SCORE(7), .RWIDTH(6)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .win(win), .lose(lose),
    .score(score), .game_over(game_over), .winner(winner), .rounds(rounds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs for n edges, then sample 1 time unit after the last edge.
  task automatic cyc(input logic [1:0] w, input logic [1:0] l, input logic c, input logic r, input int n);
    win = w; lose = l; clear = c; reset = r;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] er(input int n);
    return ROUNDS_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic expect_all(input string tag, input logic [2:0] p1, input logic [2:0] p0,
                            input logic go, input logic [1:0] wn, input int rn);
    check({tag, ".score"}, 32'({p1, p0}), 32'({p1, p0}) & 32'h3f ? 32'({p1, p0}) : 32'd0);
    check({tag, ".p0"}, 32'(score[2:0]), 32'(p0));
    check({tag, ".p1"}, 32'(score[5:3]), 32'(p1));
    check({tag, ".game_over"}, 32'(game_over), 32'(go));
    check({tag, ".winner"}, 32'(winner), 32'(wn));
    check({tag, ".rounds"}, 32'(rounds), er(rn));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    win = 2'b00; lose = 2'b00; clear = 1'b0; reset = 1'b1;

    cyc(2'b00, 2'b00, 1'b0, 1'b1, 2);
    expect_all("reset", 3'd0, 3'd0, 1'b0, 2'b00, 0);

    cyc(2'b00, 2'b11, 1'b0, 1'b0, 3);
    expect_all("floor", 3'd0, 3'd0, 1'b0, 2'b00, 3);

    cyc(2'b01, 2'b00, 1'b0, 1'b0, 5);
    expect_all("win5", 3'd0, 3'd5, 1'b0, 2'b00, 8);
    cyc(2'b00, 2'b01, 1'b0, 1'b0, 2);
    expect_all("lose2", 3'd0, 3'd3, 1'b0, 2'b00, 10);

    cyc(2'b11, 2'b01, 1'b0, 1'b0, 1);
    expect_all("both", 3'd1, 3'd3, 1'b0, 2'b00, 11);

    cyc(2'b11, 2'b00, 1'b0, 1'b0, 3);
    expect_all("to6_4", 3'd4, 3'd6, 1'b0, 2'b00, 14);
    cyc(2'b10, 2'b00, 1'b0, 1'b0, 2);
    expect_all("to6_6", 3'd6, 3'd6, 1'b0, 2'b00, 16);

    cyc(2'b11, 2'b00, 1'b0, 1'b0, 1);
    expect_all("tie_win", 3'd7, 3'd7, 1'b1, 2'b01, 17);

    cyc(2'b10, 2'b00, 1'b0, 1'b0, 1);
    cyc(2'b00, 2'b11, 1'b0, 1'b0, 1);
    expect_all("frozen", 3'd7, 3'd7, 1'b1, 2'b01, 17);

    cyc(2'b00, 2'b00, 1'b1, 1'b0, 1);
    expect_all("clear", 3'd0, 3'd0, 1'b0, 2'b00, 0);
    cyc(2'b10, 2'b00, 1'b0, 1'b0, 1);
    expect_all("after_clear", 3'd1, 3'd0, 1'b0, 2'b00, 1);

    cyc(2'b11, 2'b11, 1'b0, 1'b0, 70);
    expect_all("rounds_sat", 3'd1, 3'd0, 1'b0, 2'b00, 63);

    cyc(2'b11, 2'b00, 1'b1, 1'b0, 1);
    expect_all("clear_prio", 3'd0, 3'd0, 1'b0, 2'b00, 0);

    cyc(2'b01, 2'b00, 1'b0, 1'b0, 4);
    expect_all("pre_reset", 3'd0, 3'd4, 1'b0, 2'b00, 4);
    cyc(2'b01, 2'b00, 1'b1, 1'b1, 1);
    expect_all("mid_reset", 3'd0, 3'd0, 1'b0, 2'b00, 0);
    cyc(2'b01, 2'b00, 1'b0, 1'b0, 1);
    expect_all("post_reset", 3'd0, 3'd1, 1'b0, 2'b00, 1);

    cyc(2'b00, 2'b00, 1'b1, 1'b0, 1);
    cyc(2'b10, 2'b00, 1'b0, 1'b0, 6);
    expect_all("p1_six", 3'd6, 3'd0, 1'b0, 2'b00, 6);
    cyc(2'b10, 2'b00, 1'b0, 1'b0, 1);
    expect_all("p1_wins", 3'd7, 3'd0, 1'b1, 2'b10, 7);
    cyc(2'b10, 2'b00, 1'b0, 1'b0, 2);
    expect_all("p1_hold", 3'd7, 3'd0, 1'b1, 2'b10, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
# score_tracker

Parametrised multi-player round-score tracker for the game datapath, sitting between round-outcome logic and the score displays. Each player's score saturates between 0 and MAX_SCORE and moves up on `win` and down on `lose`. A small state machine detects the first player to reach MAX_SCORE, freezes all scores, and reports the winner until a new game is started.

## Interface
- `PLAYERS`, default 2: number of independent score channels; legal range 2..8.
- `WIDTH`, default 3: bits per score.
- `MAX_SCORE`, default 7: winning score; must satisfy 1 ≤ MAX_SCORE ≤ 2**WIDTH-1 (elaboration-time check).
- `RWIDTH`, default 6: width of the round counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  start a new game: all scores to 0, state to PLAY.
- `win`  in  PLAYERS  bit i: player i won this round (one-cycle pulse per round).
- `lose`  in  PLAYERS  bit i: player i lost this round.
- `score`  out  PLAYERS*WIDTH  packed scores; player i occupies bits [i*WIDTH +: WIDTH].
- `game_over`  out  1  high while in state OVER.
- `winner`  out  PLAYERS  one-hot winning player; all zero unless `game_over` is high.
- `rounds`  out  RWIDTH  rounds played this game (see Configuration).

## Operation
- States:
  - PLAY: scores update.
  - OVER: scores frozen.
- Reset or `clear`:
  - `score`=0, `game_over`=0, `winner`=0, `rounds`=0, state PLAY.
  - `reset` has priority over `clear`; `clear` has priority over `win`/`lose`.
- PLAY, per player i, evaluated independently:
  - `win[i]` and not `lose[i]`: +1 if score < MAX_SCORE, else hold.
  - `lose[i]` and not `win[i]`: −1 if score > 0, else hold.
  - Both or neither set: hold.
  - No wrap-around in either direction, ever.
- PLAY → OVER on the edge where any updated score equals MAX_SCORE.
  - `winner` takes the one-hot of that player.
  - If several players reach MAX_SCORE on the same edge, the lowest index wins.
- OVER:
  - `win`/`lose` are ignored.
  - `score`, `winner` and `rounds` hold.
  - Exits only on `clear` or `reset`.
- A round is counted in PLAY on any cycle where `|(win|lose)` is true, including cycles where saturation blocks the score change. The counter saturates at 2**RWIDTH-1.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Latency is 1 cycle: inputs sampled at edge N are reflected in `score` after edge N.
- `game_over` and `winner` assert on the same edge on which the winning score becomes visible on `score`.
- `clear` takes effect on the next edge; the game is playable in the following cycle.
- Reset mid-game: every output is 0 after the reset edge, regardless of the state it interrupted.
- `win`/`lose` are level-sampled each cycle. Holding `win[i]` high for k cycles adds k (saturating); edge detection is the caller's responsibility.

## Configuration
- `SCORE_TRACKER_ROUNDS_EN` defined:
  - Round counter is built.
  - `rounds` behaves as described above.
- Not defined:
  - Counter logic is omitted.
  - `rounds` is tied to constant 0.
  - All other behaviour is identical.

## Test plan
Parameters: PLAYERS=2, WIDTH=3, MAX_SCORE=7, `SCORE_TRACKER_ROUNDS_EN` defined.
- Reset, then `lose`=2'b11 for 3 cycles → scores stay 0/0 (floor); `rounds`=3.
- `win`=2'b01 for 5 cycles, then `lose`=2'b01 for 2 cycles → P0=3, P1=0, `game_over`=0.
- `win`=2'b11 and `lose`=2'b01 for one cycle with P0=3, P1=0 → P0=3, P1=1.
- From P0=6, P1=6, `win`=2'b11 for one cycle → both scores 7, `game_over`=1, `winner`=2'b01. Further `win`/`lose` pulses leave `score` and `rounds` unchanged.
- In OVER, pulse `clear` → after the next edge all outputs are 0. Then `win`=2'b10 once → P1=1, `rounds`=1.
- Assert `reset` mid-game with P0=4 and `win` held high → all outputs 0 after the reset edge, and `win` is ignored on that edge.
